// File: rtl/nn_pkg.sv
// Shared types and constants for the fully-connected layer engines.
// Build option: define NN_LAYER_RELU_EN to enable ReLU in nn_sat_act.
package nn_pkg;

    localparam int DEF_DW        = 8;
    localparam int DEF_FRAC_BITS = 4;

    // Output range for the default data width.
    localparam int SAT_MAX = (1 << (DEF_DW - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DEF_DW - 1));

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/nn_sat_act.sv
// Fixed-point rescale (arithmetic shift), saturation to the DW-bit signed
// range, and optional ReLU. Purely combinational; shared by all layers.
// Build option: NN_LAYER_RELU_EN clamps negative results to zero.
module nn_sat_act #(
    parameter int ACC_W     = 19,
    parameter int DW        = nn_pkg::DEF_DW,
    parameter int FRAC_BITS = nn_pkg::DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [DW-1:0]    res
);

    // Limits are derived from DW here so a non-default width still works.
    localparam logic signed [ACC_W-1:0] HI = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] LO = -HI - ACC_W'(1);

    logic signed [ACC_W-1:0] shifted;

    // Shift toward -inf, clamp to the output range, then apply activation.
    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if (shifted > HI) begin
            res = HI[DW-1:0];
        end else if (shifted < LO) begin
            res = LO[DW-1:0];
        end else begin
            res = shifted[DW-1:0];
        end
`ifdef NN_LAYER_RELU_EN
        if (res[DW-1]) begin
            res = '0;
        end
`endif
    end

endmodule

// File: rtl/nn_layer_engine.sv
// One fully-connected layer: out[o] = act((sum_i in[i]*W[o][i]) >>> FRAC_BITS).
// Streams reads from synchronous activation/weight buffers (1-cycle latency),
// emits one result per neuron, then pulses done.
// Build option: NN_LAYER_RELU_EN selects ReLU activation in nn_sat_act.
module nn_layer_engine
    import nn_pkg::*;
#(
    parameter int N_IN      = 8,
    parameter int N_OUT     = 4,
    parameter int DW        = DEF_DW,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_W     = 2 * DW + $clog2(N_IN)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    output logic                            busy,
    output logic                            rd_en,
    output logic [$clog2(N_IN)-1:0]         in_addr,
    output logic [$clog2(N_IN*N_OUT)-1:0]   w_addr,
    input  logic signed [DW-1:0]            in_data,
    input  logic signed [DW-1:0]            w_data,
    output logic                            out_valid,
    output logic [$clog2(N_OUT)-1:0]        out_idx,
    output logic signed [DW-1:0]            out_data,
    output logic                            done
);

    localparam int IW  = $clog2(N_IN);
    localparam int OW  = $clog2(N_OUT);
    localparam int WAW = $clog2(N_IN * N_OUT);
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

    state_t                  state, state_nxt;
    logic [IW-1:0]           i_cnt;
    logic [OW-1:0]           o_cnt;
    logic signed [ACC_W-1:0] acc;
    logic                    rv;
    logic signed [2*DW-1:0]  prod;
    logic signed [DW-1:0]    act_res;

    assign prod = in_data * w_data;

    nn_sat_act #(
        .ACC_W     (ACC_W),
        .DW        (DW),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat_act (
        .acc (acc),
        .res (act_res)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, read-valid pipe and accumulator; per-neuron clears override accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_cnt <= '0;
            o_cnt <= '0;
            acc   <= '0;
            rv    <= 1'b0;
        end else begin
            rv <= rd_en;
            if (rv) begin
                acc <= acc + $signed({{(ACC_W-2*DW){prod[2*DW-1]}}, prod});
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        i_cnt <= '0;
                        o_cnt <= '0;
                        acc   <= '0;
                    end
                end
                ST_MAC: begin
                    i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + IW'(1);
                end
                ST_WRITE: begin
                    if (o_cnt != O_LAST) begin
                        o_cnt <= o_cnt + OW'(1);
                        i_cnt <= '0;
                        acc   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        rd_en     = 1'b0;
        in_addr   = '0;
        w_addr    = '0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_data  = '0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_MAC;
            end
            ST_MAC: begin
                rd_en   = 1'b1;
                in_addr = i_cnt;
                w_addr  = WAW'(o_cnt) * WAW'(N_IN) + WAW'(i_cnt);
                if (i_cnt == I_LAST) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                out_valid = 1'b1;
                out_idx   = o_cnt;
                out_data  = act_res;
                state_nxt = (o_cnt == O_LAST) ? ST_DONE : ST_MAC;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Self-checking bench for nn_layer_engine (default parameters).
// Expected results follow NN_LAYER_RELU_EN when it is defined for the build.
module tb_nn_layer_engine;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              busy;
    logic              rd_en;
    logic [2:0]        in_addr;
    logic [4:0]        w_addr;
    logic signed [7:0] in_data;
    logic signed [7:0] w_data;
    logic              out_valid;
    logic [1:0]        out_idx;
    logic signed [7:0] out_data;
    logic              done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        int data;
    } sb_t;

    sb_t sb_q[$];
    sb_t sb_e;

    logic signed [7:0] in_mem[8];
    logic signed [7:0] w_mem[32];

    int exp_a[4];
    int exp_b[4];
    int exp_c[4];

    always #5 clk = ~clk;

    nn_layer_engine dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .busy      (busy),
        .rd_en     (rd_en),
        .in_addr   (in_addr),
        .w_addr    (w_addr),
        .in_data   (in_data),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .done      (done)
    );

    // Synchronous buffers with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            in_data <= in_mem[in_addr];
            w_data  <= w_mem[w_addr];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every result strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got idx=%0d data=%0d expected no result", out_idx, out_data);
            end else begin
                sb_e = sb_q.pop_front();
                check("out_idx", int'(out_idx), sb_e.idx);
                check("out_data", int'(out_data), sb_e.data);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_in_addr"}, int'(in_addr), 0);
        check({tag, "_w_addr"}, int'(w_addr), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_idx"}, int'(out_idx), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // One full layer, checking cycle-by-cycle timing and addresses.
    task automatic run_layer(input int expv[4], input bit poke15);
        int pos;
        int n;
        bit mac;
        for (int o = 0; o < 4; o++) sb_q.push_back('{o, expv[o]});
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            pos = (c - 1) % 10;
            n   = (c - 1) / 10;
            mac = (c <= 40) && (pos < 8);
            check($sformatf("rd_en@%0d", c), int'(rd_en), int'(mac));
            if (mac) begin
                check($sformatf("in_addr@%0d", c), int'(in_addr), pos);
                check($sformatf("w_addr@%0d", c), int'(w_addr), n * 8 + pos);
            end
            check($sformatf("busy@%0d", c), int'(busy), int'(c <= 41));
            check($sformatf("done@%0d", c), int'(done), int'(c == 41));
            check($sformatf("out_valid@%0d", c), int'(out_valid), int'(c <= 40 && pos == 9));
            if (poke15 && c == 15) enable = 1'b1;
            if (c == 16) enable = 1'b0;
        end
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
`ifdef NN_LAYER_RELU_EN
        exp_a = '{16, 0, 127, 0};
        exp_b = '{127, 0, 127, 0};
        exp_c = '{0, 0, 4, 16};
`else
        exp_a = '{16, -16, 127, -128};
        exp_b = '{127, -127, 127, -128};
        exp_c = '{-4, -1, 4, 16};
`endif
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Vector A: in=16; rows 2, -2, 127, -128 (plain, negative, both saturations).
        for (int i = 0; i < 8; i++) in_mem[i] = 8'sd16;
        for (int i = 0; i < 8; i++) begin
            w_mem[i]      = 8'sd2;
            w_mem[8 + i]  = -8'sd2;
            w_mem[16 + i] = 8'sd127;
            w_mem[24 + i] = -8'sd128;
        end
        run_layer(exp_a, 1'b1);

        // Vector B: in=127; extreme accumulator magnitudes.
        for (int i = 0; i < 8; i++) in_mem[i] = 8'sd127;
        run_layer(exp_b, 1'b0);

        // Vector C: alternating-sign inputs, floor behaviour of the shift.
        in_mem = '{8'sd1, -8'sd2, 8'sd3, -8'sd4, 8'sd5, -8'sd6, 8'sd7, -8'sd8};
        for (int i = 0; i < 8; i++) begin
            w_mem[i]      = 8'sd16;
            w_mem[8 + i]  = (i == 1) ? 8'sd1 : 8'sd0;
            w_mem[16 + i] = -8'sd16;
            w_mem[24 + i] = (i % 2 == 0) ? 8'sd16 : 8'sd0;
        end
        run_layer(exp_c, 1'b0);

        // Reset during MAC abandons the layer silently.
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("post_reset_busy@%0d", c), int'(busy), 0);
            check($sformatf("post_reset_done@%0d", c), int'(done), 0);
        end
        run_layer(exp_c, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nn_layer_engine.md
Name: nn_layer_engine

Overview:
- Responder to the network sequencer's per-layer enable pulse: computes one fully-connected layer, out[o] = act((sum_i in[i]*W[o][i]) >>> FRAC_BITS), for o = 0..N_OUT-1.
- Reads activations and weights from external synchronous buffers, streams results to the next layer's buffer, then pulses done back to the sequencer.
- One instance per layer, placed between activation buffers.

Parameters:
- N_IN, 8, input activations per neuron
- N_OUT, 4, output neurons
- DW, 8, signed width of activations, weights and outputs
- FRAC_BITS, 4, fixed-point fraction bits removed before output
- ACC_W, 2*DW+$clog2(N_IN), signed accumulator width (no overflow by construction)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  start request, sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- rd_en  out  1  read strobe to both buffers
- in_addr  out  $clog2(N_IN)  activation address
- w_addr  out  $clog2(N_IN*N_OUT)  weight address = o*N_IN + i
- in_data  in  DW  signed activation, valid the cycle after rd_en
- w_data  in  DW  signed weight, valid the cycle after rd_en
- out_valid  out  1  one-cycle result strobe
- out_idx  out  $clog2(N_OUT)  neuron index of out_data
- out_data  out  DW  signed result
- done  out  1  one-cycle pulse after the last result

Behaviour:
- Reset: state IDLE; all outputs 0; accumulator, i, o and read-valid flag cleared. Applies immediately from any state. The partial layer is abandoned with no out_valid or done.
- IDLE:
  - If enable is high: acc=0, i=0, o=0, go to MAC.
  - enable in any other state is ignored (no restart, no queueing).
- MAC (N_IN cycles):
  - rd_en=1, in_addr=i, w_addr=o*N_IN+i; i increments each cycle.
  - After i=N_IN-1 is issued, go to DRAIN.
- Read latency is fixed at 1 cycle. A registered copy of rd_en (rv) gates accumulation: acc += sext(in_data*w_data) when rv=1.
- DRAIN (1 cycle): rd_en=0; the last product is accumulated; go to WRITE.
- WRITE (1 cycle):
  - out_valid=1, out_idx=o, out_data=act(acc).
  - If o==N_OUT-1, go to DONE.
  - Otherwise o++, i=0, acc=0, go to MAC.
- DONE (1 cycle): done=1, then go to IDLE. busy drops in the same cycle the state returns to IDLE.
- Timing: each neuron takes N_IN+2 cycles. done is high in the cycle N_OUT*(N_IN+2)+1 after the enable-sampling edge (41 with defaults).
- Arithmetic:
  - Product is signed 2*DW.
  - Shift is arithmetic >>> FRAC_BITS (truncation toward -inf).
  - Saturation to [-2^(DW-1), 2^(DW-1)-1].
- A level-held enable restarts a new layer on the cycle after DONE returns to IDLE.

Optional Feature:
- Macro: NN_LAYER_RELU_EN.
- Defined: act() clamps negative saturated results to 0, so output range is [0, 2^(DW-1)-1].
- Undefined: act() is shift+saturate only, and signed negative outputs pass through.
- Timing and handshakes are identical in both builds.

Decomposition:
- Package nn_pkg:
  - DW and FRAC_BITS defaults
  - state typedef/encoding (IDLE, MAC, DRAIN, WRITE, DONE)
  - saturation constants SAT_MAX/SAT_MIN
- One sub-module: nn_sat_act, combinational shift + saturate + optional ReLU (ACC_W in, DW out), also reused by later layers.
- FSM, counters and accumulator stay in nn_layer_engine.

Test Plan:
- All in=16, W[0][*]=2, FRAC_BITS=4 -> acc=256, out_idx=0, out_data=16.
- All in=16, W[1][*]=-2 -> out_data=-16 without macro; 0 with NN_LAYER_RELU_EN.
- Saturation:
  - in=127, W[2][*]=127 -> acc=129032, out_data=127.
  - W[3][*]=-128 -> acc=-130048, out_data=-128 (0 with ReLU).
- Timing with defaults: out_valid in cycles 10/20/30/40 after the enable edge, done in cycle 41, busy high in cycles 1..41; an enable pulse at cycle 15 is ignored with no change in addresses or results.
- Reset at cycle 5 (mid-MAC) -> all outputs 0, busy 0, no out_valid/done; a new enable then restarts at o=0 and reproduces the full result set.
- Address check: w_addr sequence 0..31 in order, in_addr 0..7 repeating per neuron, rd_en low in DRAIN/WRITE/DONE.
